// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage. It owns a word-addressed data memory
// with a fixed number of wait states, stalls upstream while an access is in
// flight, and presents WB control, ALU result, load data and the destination
// register to MEM2WB. Non-memory instructions pass through combinationally.
module mem_stage #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB_IN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] ST_valIn,
    input  logic [4:0]  destIn,
    output logic [1:0]  WB_Out,
    output logic [31:0] ALUResOut,
    output logic [31:0] memReadOut,
    output logic [4:0]  destOut,
    output logic        freeze
);
    localparam int         AW       = $clog2(DEPTH);
    localparam bit         HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [2:0] CNT_INIT = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          req;
    logic          is_load;
    logic          is_store;
    logic          done;
    logic          wr_en;
    logic          unused_addr;

    // Word index: byte offset dropped, high bits ignored so addresses wrap.
    assign idx         = ALUResIn[AW+1:2];
    assign unused_addr = ^{ALUResIn[31:AW+2], ALUResIn[1:0]};

    // A simultaneous read and write request is treated as a store only.
    assign req      = MEM_R_EN | MEM_W_EN;
    assign is_store = MEM_W_EN;
    assign is_load  = MEM_R_EN & ~MEM_W_EN;

    // Decide whether this cycle stalls or completes an access; reset forces
    // pure pass-through immediately, including dropping a pending stall.
    always_comb begin
        done   = 1'b0;
        freeze = 1'b0;
        if (!rst) begin
            if (state == S_WAIT) begin
                if (cnt != 3'd0) freeze = 1'b1;
                else             done   = req;
            end else if (req) begin
                if (HAS_WAIT) freeze = 1'b1;
                else          done   = 1'b1;
            end
        end
    end

    assign wr_en      = done & is_store;
    assign WB_Out     = freeze ? 2'b00 : WB_IN;
    assign ALUResOut  = ALUResIn;
    assign destOut    = destIn;
    assign memReadOut = (done && is_load) ? mem[idx] : 32'd0;

    // Wait-state sequencer: start on a request in IDLE, count down, return at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && HAS_WAIT) begin
                        state <= S_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) state <= S_IDLE;
                    else             cnt   <= cnt - 3'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data memory write port; only the completion cycle of a store writes.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= ST_valIn;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (wait states 2, 0, 3) driven by directed
// vectors, an age-based behavioural model checked every cycle, plus literal
// expectations taken from hand-worked cases.
module tb_mem_stage;
    localparam int NI = 3;

    logic        clk;
    logic        rst      [NI];
    logic [1:0]  wb_in    [NI];
    logic        r_en     [NI];
    logic        w_en     [NI];
    logic [31:0] alu_in   [NI];
    logic [31:0] st_val   [NI];
    logic [4:0]  dest_in  [NI];
    logic [1:0]  wb_out   [NI];
    logic [31:0] alu_out  [NI];
    logic [31:0] rd_out   [NI];
    logic [4:0]  dest_out [NI];
    logic        frz      [NI];

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    function automatic int ws_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int WS = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
        mem_stage #(.DEPTH(64), .WAIT_STATES(WS)) dut (
            .clk(clk), .rst(rst[g]), .WB_IN(wb_in[g]), .MEM_R_EN(r_en[g]),
            .MEM_W_EN(w_en[g]), .ALUResIn(alu_in[g]), .ST_valIn(st_val[g]),
            .destIn(dest_in[g]), .WB_Out(wb_out[g]), .ALUResOut(alu_out[g]),
            .memReadOut(rd_out[g]), .destOut(dest_out[g]), .freeze(frz[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // age = number of cycles the current request has already been presented.
    // A request completes in the cycle where age reaches the wait-state count.
    int          age [NI];
    logic [31:0] mmem [int];

    function automatic int key_of(int k, logic [31:0] a);
        return k * 1024 + int'((a >> 2) % 64);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst[k]) begin
                if (r_en[k] || w_en[k]) begin
                    if (age[k] >= ws_of(k)) begin
                        if (w_en[k]) mmem[key_of(k, alu_in[k])] = st_val[k];
                        age[k] = 0;
                    end else begin
                        age[k] = age[k] + 1;
                    end
                end else begin
                    age[k] = 0;
                end
            end
        end
    end

    always @(posedge rst[0] or posedge rst[1] or posedge rst[2]) begin
        for (int k = 0; k < NI; k++) if (rst[k]) age[k] = 0;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                bit          rq;
                bit          ef;
                logic [1:0]  ewb;
                int          ky;
                if (!rst[k]) begin
                    rq  = r_en[k] || w_en[k];
                    ef  = rq && (age[k] < ws_of(k));
                    ewb = ef ? 2'b00 : wb_in[k];
                    ky  = key_of(k, alu_in[k]);
                    chk($sformatf("m%0d.freeze", k), {31'd0, frz[k]}, {31'd0, ef});
                    chk($sformatf("m%0d.wb", k), {30'd0, wb_out[k]}, {30'd0, ewb});
                    chk($sformatf("m%0d.alu", k), alu_out[k], alu_in[k]);
                    chk($sformatf("m%0d.dest", k), {27'd0, dest_out[k]}, {27'd0, dest_in[k]});
                    if (!ef && r_en[k] && !w_en[k]) begin
                        if (mmem.exists(ky)) chk($sformatf("m%0d.rd", k), rd_out[k], mmem[ky]);
                    end else begin
                        chk($sformatf("m%0d.rd", k), rd_out[k], 32'd0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int k, input logic [1:0] wb, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] v, input logic [4:0] d);
        wb_in[k] = wb; r_en[k] = r; w_en[k] = w; alu_in[k] = a; st_val[k] = v; dest_in[k] = d;
    endtask

    task automatic idle(input int k);
        drive(k, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a memory op for n cycles, checking freeze each cycle against the
    // hand-derived pattern (high for all but the last). Returns last-cycle read data.
    task automatic hold_op(input int k, input int n, input string nm, output logic [31:0] rd,
                           output logic [1:0] wb);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s.frz%0d", nm, i), {31'd0, frz[k]}, (i == n - 1) ? 32'd0 : 32'd1);
            rd = rd_out[k];
            wb = wb_out[k];
            step();
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  wb;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            age[k] = 0;
            idle(k);
        end
        drive(0, 2'b11, 1'b1, 1'b0, 32'h40, 32'd0, 5'd3);
        #3;
        // In reset even a request must not stall.
        chk("reset.freeze", {31'd0, frz[0]}, 32'd0);
        chk("reset.wb", {30'd0, wb_out[0]}, 32'd3);
        chk("reset.rd", rd_out[0], 32'd0);
        idle(0);
        #8;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        started = 1'b1;
        step();

        // Pass-through
        drive(0, 2'b10, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd5);
        @(negedge clk);
        chk("pass.wb", {30'd0, wb_out[0]}, 32'h2);
        chk("pass.alu", alu_out[0], 32'h1234);
        chk("pass.dest", {27'd0, dest_out[0]}, 32'd5);
        chk("pass.rd", rd_out[0], 32'd0);
        chk("pass.frz", {31'd0, frz[0]}, 32'd0);
        step();

        // Store then load, 2 wait states
        drive(0, 2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
        hold_op(0, 3, "st10", rd, wb);
        drive(0, 2'b11, 1'b1, 1'b0, 32'h10, 32'd0, 5'd7);
        hold_op(0, 3, "ld10", rd, wb);
        chk("ld10.rd", rd, 32'hDEADBEEF);
        chk("ld10.wb", {30'd0, wb}, 32'h3);

        // Wrap and alignment: 0x13 and 0x113 both map to index 4
        drive(0, 2'b00, 1'b0, 1'b1, 32'h13, 32'hA5A5A5A5, 5'd0);
        hold_op(0, 3, "st13", rd, wb);
        drive(0, 2'b11, 1'b1, 1'b0, 32'h113, 32'd0, 5'd9);
        hold_op(0, 3, "ld113", rd, wb);
        chk("ld113.rd", rd, 32'hA5A5A5A5);

        // Simultaneous R/W is a store only
        drive(0, 2'b11, 1'b1, 1'b1, 32'h0, 32'h55, 5'd1);
        hold_op(0, 3, "rw0", rd, wb);
        chk("rw0.rd", rd, 32'd0);
        drive(0, 2'b11, 1'b1, 1'b0, 32'h0, 32'd0, 5'd1);
        hold_op(0, 3, "ld0", rd, wb);
        chk("ld0.rd", rd, 32'h55);
        idle(0);
        step();

        // Zero latency on instance 1
        drive(1, 2'b00, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 5'd0);
        hold_op(1, 1, "z.st", rd, wb);
        drive(1, 2'b11, 1'b1, 1'b0, 32'h8, 32'd0, 5'd2);
        hold_op(1, 1, "z.ld", rd, wb);
        chk("z.ld.rd", rd, 32'hCAFEF00D);
        chk("z.ld.wb", {30'd0, wb}, 32'h3);
        idle(1);
        step();

        // Reset mid-store on instance 2 (3 wait states)
        drive(2, 2'b00, 1'b0, 1'b1, 32'h20, 32'h11111111, 5'd0);
        hold_op(2, 4, "r.st1", rd, wb);
        drive(2, 2'b00, 1'b0, 1'b1, 32'h20, 32'h22222222, 5'd0);
        @(negedge clk);
        chk("r.st2.frz0", {31'd0, frz[2]}, 32'd1);
        step();
        #1;
        rst[2] = 1'b1;
        #1;
        chk("r.rst.frz", {31'd0, frz[2]}, 32'd0);
        idle(2);
        #1;
        rst[2] = 1'b0;
        step();
        drive(2, 2'b11, 1'b1, 1'b0, 32'h20, 32'd0, 5'd4);
        hold_op(2, 4, "r.ld", rd, wb);
        chk("r.ld.rd", rd, 32'h11111111);
        idle(2);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
